// File: rtl/cnt_seq_monitor.sv
// Receive-side checker for a signed up-counter stream: tracks the expected next
// sample, flags illegal transitions and keeps wrap/restart/error/run statistics.
module cnt_seq_monitor #(
    parameter int W     = 5,
    parameter int CW    = 8,
    parameter int RW    = 6,
    parameter int TOP   = 15,
    parameter int START = -5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                src_rst,
    input  logic                in_vld,
    input  logic signed [W-1:0] in_num,
    input  logic                clr,
    output logic                err,
    output logic                err_sticky,
    output logic [CW-1:0]       err_cnt,
    output logic [CW-1:0]       wrap_cnt,
    output logic [CW-1:0]       restart_cnt,
    output logic [RW-1:0]       run_len,
    output logic [RW-1:0]       max_run,
    output logic                tracking
);

    localparam logic signed [W-1:0] TOP_V   = W'(TOP);
    localparam logic signed [W-1:0] START_V = W'(START);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_TRACK = 2'd2
    } state_t;

    state_t              state;
    logic signed [W-1:0] p;

    // p+1 is formed one bit wider so TOP+1 can never alias onto the most negative sample.
    logic signed [W:0] p_inc;
    logic signed [W:0] v_ext;
    logic              is_step;
    logic              is_zero;
    logic              is_wrap;
    logic              is_restart;
    logic              is_err;
    logic [RW-1:0]     run_inc;
    logic [CW-1:0]     err_inc;
    logic [CW-1:0]     wrap_inc;
    logic [CW-1:0]     restart_inc;

    always_comb begin
        p_inc       = {p[W-1], p} + (W+1)'(1);
        v_ext       = {in_num[W-1], in_num};
        is_step     = (v_ext == p_inc);
        is_zero     = (in_num == '0);
        is_wrap     = is_zero && (p == TOP_V);
        is_restart  = is_zero && !is_step && !is_wrap;
        is_err      = !is_step && !is_zero;
        run_inc     = (&run_len)     ? run_len     : run_len + RW'(1);
        err_inc     = (&err_cnt)     ? err_cnt     : err_cnt + CW'(1);
        wrap_inc    = (&wrap_cnt)    ? wrap_cnt    : wrap_cnt + CW'(1);
        restart_inc = (&restart_cnt) ? restart_cnt : restart_cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            p           <= '0;
            err         <= 1'b0;
            err_sticky  <= 1'b0;
            err_cnt     <= '0;
            wrap_cnt    <= '0;
            restart_cnt <= '0;
            run_len     <= '0;
            max_run     <= '0;
            tracking    <= 1'b0;
        end else begin
            err <= 1'b0;
            if (src_rst) begin
                state    <= S_START;
                tracking <= 1'b0;
            end else if (in_vld) begin
                p        <= in_num;
                state    <= S_TRACK;
                tracking <= 1'b1;
                unique case (state)
                    S_IDLE: begin
                    end
                    S_START: begin
                        if (in_num != START_V) begin
                            err        <= 1'b1;
                            err_sticky <= 1'b1;
                            err_cnt    <= err_inc;
                            run_len    <= '0;
                        end
                    end
                    S_TRACK: begin
                        if (is_step) begin
                            run_len <= run_inc;
                            max_run <= (run_inc > max_run) ? run_inc : max_run;
                        end else if (is_wrap) begin
                            wrap_cnt <= wrap_inc;
                            run_len  <= '0;
                        end else if (is_restart) begin
                            restart_cnt <= restart_inc;
                            run_len     <= '0;
                        end else if (is_err) begin
                            err        <= 1'b1;
                            err_sticky <= 1'b1;
                            err_cnt    <= err_inc;
                            run_len    <= '0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            // Clearing overrides any statistic update from a sample in the same cycle.
            if (clr) begin
                err_sticky  <= 1'b0;
                err_cnt     <= '0;
                wrap_cnt    <= '0;
                restart_cnt <= '0;
                run_len     <= '0;
                max_run     <= '0;
            end
        end
    end

endmodule
